// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD command sequencer:
// FSM state encoding, command opcodes and the fixed power-up init ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_LOAD,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        LONGWAIT
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

    localparam int INIT_LEN = 4;

    // Element 0 is sent first.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        LCD_CMD_ENTRY, LCD_CMD_CLEAR, LCD_CMD_DISPON, LCD_CMD_FUNCSET
    };

    // Clear and home need extra settle time inside the controller.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_tick_timer.sv
// Free-running tick timer: counts 0..TICK_CYCLES-1 and raises otick during the
// last count. iclear restarts it so a new phase always begins on a tick boundary.
module lcd_tick_timer #(
    parameter int TICK_CYCLES = 50000
) (
    input  logic iclk,
    input  logic ireset,
    input  logic iclear,
    output logic otick
);

    localparam logic [31:0] LAST_COUNT    = 32'(TICK_CYCLES - 1);
    localparam logic [31:0] PRELAST_COUNT = 32'(TICK_CYCLES - 2);

    logic [31:0] count_q, count_d;
    logic        tick_q, tick_d;

    always_comb begin
        count_d = count_q + 32'd1;
        if (iclear || (count_q == LAST_COUNT)) begin
            count_d = '0;
        end
        // Registered one cycle early so otick lines up with the last count.
        tick_d = !iclear && (count_q == PRELAST_COUNT);
    end

    // NOTE: nonblocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign otick = tick_q;

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style LCD sequencer: power-up wait, fixed init sequence, then
// upstream bytes over valid/ready, each driven as setup / enable / hold phases.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int TICK_CYCLES     = 50000,
    parameter int POWERUP_TICKS   = 20,
    parameter int LONG_WAIT_TICKS = 2
) (
    input  logic       iclk,
    input  logic       ireset,
    input  logic       ivalid,
    input  logic       irs,
    input  logic [7:0] idata,
    output logic       ordy,
    output logic       oinit_done,
    output logic [7:0] olcd_data,
    output logic       olcd_rs,
    output logic       olcd_rw,
    output logic       olcd_en,
    output logic       olcd_on
);

    lcd_state_t  state_q, state_d;
    logic [15:0] ticks_q, ticks_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        rdy_q, rdy_d;
    logic        done_q, done_d;
    logic        tick;
    logic        timer_clear;
    logic        byte_done;

    assign timer_clear = (state_d != state_q);

    lcd_tick_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_timer (
        .iclk  (iclk),
        .ireset(ireset),
        .iclear(timer_clear),
        .otick (tick)
    );

    // NOTE: every _d gets its current value first so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        ticks_d   = ticks_q;
        idx_d     = idx_q;
        data_d    = data_q;
        rs_d      = rs_q;
        done_d    = done_q;
        byte_done = 1'b0;

        unique case (state_q)
            PWRUP: begin
                if (tick) begin
                    if (ticks_q == 16'(POWERUP_TICKS - 1)) begin
                        state_d = INIT_LOAD;
                        ticks_d = '0;
                        idx_d   = '0;
                    end else begin
                        ticks_d = ticks_q + 16'd1;
                    end
                end
            end
            INIT_LOAD: begin
                data_d  = INIT_ROM[idx_q[1:0]];
                rs_d    = 1'b0;
                state_d = SETUP;
            end
            IDLE: begin
                if (ivalid) begin
                    data_d  = idata;
                    rs_d    = irs;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = PULSE;
            end
            PULSE: begin
                if (tick) state_d = HOLD;
            end
            HOLD: begin
                if (tick) begin
                    if (needs_long_wait(rs_q, data_q) && (LONG_WAIT_TICKS > 0)) begin
                        state_d = LONGWAIT;
                        ticks_d = '0;
                    end else begin
                        byte_done = 1'b1;
                    end
                end
            end
            LONGWAIT: begin
                if (tick) begin
                    if (ticks_q == 16'(LONG_WAIT_TICKS - 1)) begin
                        byte_done = 1'b1;
                    end else begin
                        ticks_d = ticks_q + 16'd1;
                    end
                end
            end
            default: state_d = PWRUP;
        endcase

        // A finished byte either advances the init sequence or returns to IDLE.
        if (byte_done) begin
            ticks_d = '0;
            if (!done_q) begin
                idx_d = idx_q + 3'd1;
                if (idx_d < 3'(INIT_LEN)) begin
                    state_d = INIT_LOAD;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end else begin
                state_d = IDLE;
            end
        end

        rdy_d = (state_d == IDLE);
        en_d  = (state_d == PULSE);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= PWRUP;
            ticks_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ticks_q <= ticks_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign ordy       = rdy_q;
    assign oinit_done = done_q;
    assign olcd_data  = data_q;
    assign olcd_rs    = rs_q;
    assign olcd_en    = en_q;
    assign olcd_rw    = 1'b0;
    assign olcd_on    = 1'b1;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: a strobe scoreboard checks every
// enable pulse's byte and width; scenario tasks check cycle-exact timing.
module tb_lcd_cmd_sequencer;

    localparam int T  = 4;
    localparam int P  = 3;
    localparam int LW = 2;

    logic       iclk   = 1'b0;
    logic       ireset = 1'b1;
    logic       ivalid = 1'b0;
    logic       irs    = 1'b0;
    logic [7:0] idata  = 8'h00;
    logic       ordy;
    logic       oinit_done;
    logic [7:0] olcd_data;
    logic       olcd_rs;
    logic       olcd_rw;
    logic       olcd_en;
    logic       olcd_on;

    lcd_cmd_sequencer #(
        .TICK_CYCLES    (T),
        .POWERUP_TICKS  (P),
        .LONG_WAIT_TICKS(LW)
    ) dut (
        .iclk      (iclk),
        .ireset    (ireset),
        .ivalid    (ivalid),
        .irs       (irs),
        .idata     (idata),
        .ordy      (ordy),
        .oinit_done(oinit_done),
        .olcd_data (olcd_data),
        .olcd_rs   (olcd_rs),
        .olcd_rw   (olcd_rw),
        .olcd_en   (olcd_en),
        .olcd_on   (olcd_on)
    );

    always #5 iclk = ~iclk;

    int ncyc = 0;
    always @(posedge iclk) ncyc <= ncyc + 1;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] exp_q[$];
    int         rise_q[$];
    logic       abort_pulse = 1'b0;
    logic [7:0] init_bytes[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Strobe monitor: byte on each rising enable, stability and width of each pulse.
    initial begin
        logic       en_prev;
        int         en_start;
        logic [7:0] en_data;
        logic       en_rs;
        logic [8:0] exp;
        en_prev  = 1'b0;
        en_start = 0;
        en_data  = 8'h00;
        en_rs    = 1'b0;
        forever begin
            @(negedge iclk);
            if (olcd_en && !en_prev) begin
                rise_q.push_back(ncyc);
                en_start = ncyc;
                en_data  = olcd_data;
                en_rs    = olcd_rs;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL strobe_unexpected: got rs=%0b data=%02h at cycle %0d, expected no strobe",
                             olcd_rs, olcd_data, ncyc);
                end else begin
                    exp = exp_q.pop_front();
                    if ({olcd_rs, olcd_data} !== exp) begin
                        miscompares++;
                        $display("FAIL strobe_byte: got rs=%0b data=%02h, expected rs=%0b data=%02h",
                                 olcd_rs, olcd_data, exp[8], exp[7:0]);
                    end
                end
            end else if (olcd_en && en_prev) begin
                vectors++;
                if ({olcd_rs, olcd_data} !== {en_rs, en_data}) begin
                    miscompares++;
                    $display("FAIL strobe_stable: got rs=%0b data=%02h, expected rs=%0b data=%02h",
                             olcd_rs, olcd_data, en_rs, en_data);
                end
            end else if (!olcd_en && en_prev) begin
                if (!abort_pulse) begin
                    vectors++;
                    if (ncyc - en_start !== T) begin
                        miscompares++;
                        $display("FAIL strobe_width: got %0d cycles, expected %0d", ncyc - en_start, T);
                    end
                end
                abort_pulse = 1'b0;
            end
            if (olcd_en && ordy) begin
                vectors++;
                miscompares++;
                $display("FAIL rdy_during_en: got ordy=1 with olcd_en=1 at cycle %0d, expected ordy=0", ncyc);
            end
            en_prev = olcd_en;
        end
    end

    function automatic int strobe_rise(input int p, input int k);
        return p + P * T + 1 + T + k * (1 + 3 * T) + ((k == 3) ? LW * T : 0);
    endfunction

    task automatic push_init();
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, init_bytes[k]});
    endtask

    task automatic check_rise(input string name, input int expected);
        int got;
        vectors++;
        if (rise_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got no strobe, expected rise at cycle %0d", name, expected);
        end else begin
            got = rise_q.pop_front();
            if (got !== expected) begin
                miscompares++;
                $display("FAIL %s: got rise at cycle %0d, expected %0d", name, got, expected);
            end
        end
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] data, output int acc);
        @(negedge iclk);
        ivalid = 1'b1;
        irs    = rs;
        idata  = data;
        acc    = -1;
        for (int i = 0; i < 200; i++) begin
            if (ordy) begin
                acc = ncyc;
                exp_q.push_back({rs, data});
                break;
            end
            @(negedge iclk);
        end
        if (acc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no ordy within 200 cycles, expected acceptance");
        end
    endtask

    task automatic wait_ordy(output int when);
        when = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge iclk);
            if (ordy) begin
                when = ncyc;
                break;
            end
        end
    endtask

    // Called at the negedge of the first PWRUP cycle p.
    task automatic run_powerup(input int p);
        logic early;
        logic done_prev;
        int   rdy_at;
        early     = 1'b0;
        done_prev = 1'b0;
        rdy_at    = -1;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) @(negedge iclk);
            if ((ncyc < p + P * T) && olcd_en) early = 1'b1;
            if (ordy) begin
                rdy_at = ncyc;
                break;
            end
            done_prev = oinit_done;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL powerup_quiet: got olcd_en=1 during power-up wait, expected 0");
        end
        vectors++;
        if (rdy_at !== p + P * T + 4 * (1 + 3 * T) + LW * T) begin
            miscompares++;
            $display("FAIL init_ready_time: got cycle %0d, expected %0d",
                     rdy_at, p + P * T + 4 * (1 + 3 * T) + LW * T);
        end
        vectors++;
        if ({done_prev, oinit_done} !== 2'b01) begin
            miscompares++;
            $display("FAIL init_done_edge: got before/at=%02b, expected 01", {done_prev, oinit_done});
        end
        for (int k = 0; k < 4; k++) check_rise("init_strobe_time", strobe_rise(p, k));
    endtask

    task automatic test_reset();
        int p;
        ireset = 1'b1;
        repeat (3) @(negedge iclk);
        vectors++;
        if ({ordy, oinit_done, olcd_data, olcd_rs, olcd_en, olcd_rw, olcd_on} !== {2'b00, 8'h00, 4'b0001}) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%0b done=%0b data=%02h rs=%0b en=%0b rw=%0b on=%0b, expected 0 0 00 0 0 0 1",
                     ordy, oinit_done, olcd_data, olcd_rs, olcd_en, olcd_rw, olcd_on);
        end
        ireset = 1'b0;
        p = ncyc;
        push_init();
        run_powerup(p);
    endtask

    task automatic test_char_write();
        int a, w;
        send_byte(1'b1, 8'h41, a);
        @(negedge iclk);
        ivalid = 1'b0;
        vectors++;
        if ({olcd_rs, olcd_data, ordy} !== {1'b1, 8'h41, 1'b0}) begin
            miscompares++;
            $display("FAIL char_setup: got rs=%0b data=%02h rdy=%0b, expected 1 41 0", olcd_rs, olcd_data, ordy);
        end
        wait_ordy(w);
        vectors++;
        if (w !== a + 13) begin
            miscompares++;
            $display("FAIL char_ready_time: got %0d, expected %0d", w, a + 13);
        end
        check_rise("char_strobe_time", a + 5);
    endtask

    task automatic test_busy_ignore();
        int a, w;
        send_byte(1'b1, 8'h41, a);
        for (int i = 1; i <= 8; i++) begin
            @(negedge iclk);
            vectors++;
            if ({olcd_rs, olcd_data} !== {1'b1, 8'h41}) begin
                miscompares++;
                $display("FAIL busy_hold: got rs=%0b data=%02h, expected rs=1 data=41", olcd_rs, olcd_data);
            end
            ivalid = i[0];
            irs    = 1'b0;
            idata  = 8'hFF;
        end
        @(negedge iclk);
        ivalid = 1'b0;
        wait_ordy(w);
        vectors++;
        if (w !== a + 13) begin
            miscompares++;
            $display("FAIL busy_ready_time: got %0d, expected %0d", w, a + 13);
        end
        vectors++;
        if (rise_q.size() !== 1) begin
            miscompares++;
            $display("FAIL busy_strobe_count: got %0d strobes, expected 1", rise_q.size());
        end
        check_rise("busy_strobe_time", a + 5);
    endtask

    task automatic test_back_to_back();
        int a1, a2, w;
        send_byte(1'b1, 8'h48, a1);
        @(negedge iclk);
        idata = 8'h49;
        a2 = -1;
        for (int i = 0; i < 200; i++) begin
            if (ordy) begin
                a2 = ncyc;
                exp_q.push_back({1'b1, 8'h49});
                break;
            end
            @(negedge iclk);
        end
        vectors++;
        if (a2 !== a1 + 13) begin
            miscompares++;
            $display("FAIL b2b_second_accept: got %0d, expected %0d", a2, a1 + 13);
        end
        vectors++;
        if (olcd_data !== 8'h48) begin
            miscompares++;
            $display("FAIL b2b_idle_hold: got data=%02h, expected 48", olcd_data);
        end
        @(negedge iclk);
        ivalid = 1'b0;
        vectors++;
        if (olcd_data !== 8'h49) begin
            miscompares++;
            $display("FAIL b2b_second_setup: got data=%02h, expected 49", olcd_data);
        end
        wait_ordy(w);
        vectors++;
        if (w !== a2 + 13) begin
            miscompares++;
            $display("FAIL b2b_ready_time: got %0d, expected %0d", w, a2 + 13);
        end
        check_rise("b2b_first_strobe", a1 + 5);
        check_rise("b2b_second_strobe", a2 + 5);
    endtask

    task automatic test_clear();
        int a, w;
        send_byte(1'b0, 8'h01, a);
        @(negedge iclk);
        ivalid = 1'b0;
        wait_ordy(w);
        vectors++;
        if (w !== a + 21) begin
            miscompares++;
            $display("FAIL clear_ready_time: got %0d, expected %0d", w, a + 21);
        end
        check_rise("clear_strobe_time", a + 5);
    endtask

    task automatic test_reset_mid_pulse();
        int a, at, p;
        send_byte(1'b1, 8'h41, a);
        @(negedge iclk);
        ivalid = 1'b0;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            if (olcd_en) begin
                at = ncyc;
                break;
            end
            @(negedge iclk);
        end
        vectors++;
        if (at !== a + 5) begin
            miscompares++;
            $display("FAIL midrst_en_time: got %0d, expected %0d", at, a + 5);
        end
        abort_pulse = 1'b1;
        ireset      = 1'b1;
        @(negedge iclk);
        vectors++;
        if ({olcd_en, ordy, oinit_done, olcd_data, olcd_rs} !== {3'b000, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_values: got en=%0b rdy=%0b done=%0b data=%02h rs=%0b, expected 0 0 0 00 0",
                     olcd_en, ordy, oinit_done, olcd_data, olcd_rs);
        end
        ireset = 1'b0;
        p = ncyc;
        check_rise("midrst_aborted_strobe", a + 5);
        push_init();
        run_powerup(p);
    endtask

    initial begin
        test_reset();
        test_char_write();
        test_busy_ignore();
        test_back_to_back();
        test_clear();
        test_reset_mid_pulse();
        repeat (2) @(negedge iclk);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending strobes, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Drives the HD44780-style character LCD from the 50 MHz system clock.
- Uses an internal tick timer, so the LCD path needs no derived divided clock.
- After reset it runs the power-up wait and a fixed init sequence, then accepts command/character bytes from upstream over a valid/ready handshake.
- Each accepted byte is sequenced onto the LCD pins as setup, enable-pulse and hold phases.

Parameters:
- TICK_CYCLES, 50000: iclk cycles per timing tick (1 ms at 50 MHz). Minimum 2.
- POWERUP_TICKS, 20: ticks to wait after reset before the first init byte.
- LONG_WAIT_TICKS, 2: extra HOLD ticks after a clear (0x01) or home (0x02) command.

Ports:
- iclk  input  1  system clock, 50 MHz.
- ireset  input  1  synchronous, active-high reset.
- ivalid  input  1  upstream has a byte to send.
- irs  input  1  register select with the byte: 0 = command, 1 = character data.
- idata  input  8  byte to send.
- ordy  output  1  block can accept a byte this cycle.
- oinit_done  output  1  init sequence complete; sticky until reset.
- olcd_data  output  8  LCD data bus.
- olcd_rs  output  1  LCD register select.
- olcd_rw  output  1  LCD read/write; constant 0 (write-only).
- olcd_en  output  1  LCD enable strobe.
- olcd_on  output  1  LCD power; constant 1.

Behaviour:
- Reset values: ordy=0, oinit_done=0, olcd_data=0x00, olcd_rs=0, olcd_en=0, olcd_rw=0, olcd_on=1. The state machine goes to PWRUP and the tick counter clears.
- Tick timer:
  - Counts 0..TICK_CYCLES-1 and asserts a terminal pulse on the last count.
  - Clears on every state transition, so every phase lasts exactly an integer number of whole ticks.
- States: PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, LONGWAIT.
  - PWRUP: waits POWERUP_TICKS ticks, then goes to INIT_LOAD with the init index at 0.
  - INIT_LOAD: latches ROM[index] with rs=0 into the output register, then goes to SETUP. Takes 1 cycle.
  - Init ROM order: 0x38 (8-bit, 2-line), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment).
  - IDLE: ordy=1. When ivalid&ordy, the block latches idata/irs and goes to SETUP on the next edge. ordy drops in the same edge.
  - SETUP, 1 tick: olcd_data/olcd_rs driven from the latch, olcd_en=0.
  - PULSE, 1 tick: olcd_en=1, data/rs held.
  - HOLD, 1 tick: olcd_en=0, data/rs held.
  - After HOLD: if the latched byte is rs=0 with data 0x01 or 0x02, go to LONGWAIT for LONG_WAIT_TICKS ticks; otherwise continue.
  - After HOLD/LONGWAIT during init: increment the index. If the index is below 4, go to INIT_LOAD; otherwise set oinit_done=1 and go to IDLE.
  - After HOLD/LONGWAIT outside init: go to IDLE.
- Timing, with T = TICK_CYCLES and acceptance at cycle A:
  - SETUP: cycles A+1..A+T.
  - olcd_en=1: cycles A+T+1..A+2T.
  - HOLD: cycles A+2T+1..A+3T.
  - ordy=1 again at A+3T+1, or at A+3T+1+LONG_WAIT_TICKS*T for clear/home.
- olcd_data/olcd_rs keep their last value while in IDLE.
- ordy is 0 in every state except IDLE. ivalid and idata changes outside an accepting cycle are ignored.
- Reset mid-operation: ireset wins over every transition. On the next edge all outputs take reset values, even mid-PULSE, and the full power-up and init sequence reruns.
- Commands 0x01/0x02 from upstream get the same long wait as during init.
- olcd_en changes only from registers; no combinational path from any input to any output.

Decomposition:
- Package lcd_pkg contains:
  - the state enum lcd_state_t;
  - localparams LCD_CMD_FUNCSET=8'h38, LCD_CMD_DISPON=8'h0C, LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02, LCD_CMD_ENTRY=8'h06;
  - the init ROM as a constant array with INIT_LEN=4.
- Sub-module lcd_tick_timer:
  - parameter TICK_CYCLES;
  - ports iclk, ireset, iclear, otick;
  - 32-bit counter; otick is the registered terminal pulse.
- The sequencer instantiates one lcd_tick_timer and is otherwise a single FSM.

Test Plan (TICK_CYCLES=4, POWERUP_TICKS=3, LONG_WAIT_TICKS=2):
- Power-up: release ireset.
  - olcd_en stays 0 for 12 cycles.
  - Four strobes follow with rs=0 and data 0x38, 0x0C, 0x01, 0x06; each olcd_en pulse is exactly 4 cycles wide.
  - After 0x01 there are 8 extra idle cycles before the 0x06 setup.
  - oinit_done and ordy rise together after the 0x06 HOLD.
- Character write: ivalid=1, irs=1, idata=0x41 accepted at A.
  - olcd_data=0x41 and olcd_rs=1 from A+1.
  - olcd_en=1 exactly on A+5..A+8.
  - ordy=1 at A+13.
- Back-to-back: hold ivalid=1 with 0x48 then 0x49 queued by the bench.
  - The second byte is accepted only at A+13.
  - EN pulses never overlap; data changes only in SETUP.
- Busy ignore: after accepting 0x41, toggle idata to 0xFF and irs to 0 during SETUP/PULSE.
  - olcd_data stays 0x41 and olcd_rs stays 1 throughout.
  - No extra strobe occurs.
- Clear command: irs=0, idata=0x01 accepted at A.
  - Normal strobe on A+5..A+8.
  - ordy returns at A+21.
- Reset mid-pulse: assert ireset for 1 cycle while olcd_en=1.
  - Next edge: olcd_en=0, ordy=0, oinit_done=0, olcd_data=0x00.
  - The full power-up and 4-byte init repeats identically to scenario 1.
